// File: rtl/x_lut5_cfg_loader_pkg.sv
// x_lut5_pkg: shared types and sizes for the run-time reconfigurable LUT5 loader.
//   TABLE_W : truth table width (one bit per 5-bit address)
//   CNT_W   : width of the serial shift bit counter
//   table_t : truth table word
//   state_e : loader FSM states
package x_lut5_pkg;
    localparam int TABLE_W = 32;
    localparam int CNT_W   = 5;

    typedef logic [TABLE_W-1:0] table_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;
endpackage

// File: rtl/x_lut5_cfg_loader_if.sv
// x_lut5_cfg_loader_if: configuration handshake bundle between an upstream
// controller (master) and the LUT5 loader (slave).
//   CFG_DATA  : new truth table, bit n = output for address n
//   CFG_VALID : CFG_DATA valid, held until CFG_READY
//   CFG_READY : loader can accept a word
//   CFG_BUSY  : shift or commit in progress
//   CFG_DONE  : one-cycle pulse when the new table becomes active
// Optional (X_LUT5_CFG_PARITY_EN):
//   CFG_PAR   : even parity over CFG_DATA
//   CFG_ERR   : one-cycle pulse when a word is rejected for bad parity
interface x_lut5_cfg_loader_if;
    import x_lut5_pkg::*;

    table_t CFG_DATA;
    logic   CFG_VALID;
    logic   CFG_READY;
    logic   CFG_BUSY;
    logic   CFG_DONE;
`ifdef X_LUT5_CFG_PARITY_EN
    logic   CFG_PAR;
    logic   CFG_ERR;

    modport master (output CFG_DATA, CFG_VALID, CFG_PAR,
                    input  CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR);
    modport slave  (input  CFG_DATA, CFG_VALID, CFG_PAR,
                    output CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR);
`else
    modport master (output CFG_DATA, CFG_VALID,
                    input  CFG_READY, CFG_BUSY, CFG_DONE);
    modport slave  (input  CFG_DATA, CFG_VALID,
                    output CFG_READY, CFG_BUSY, CFG_DONE);
`endif
endinterface

// File: rtl/x_lut5_cfg_loader_shifter.sv
// x_lut5_cfg_shifter: input holding register, serial shadow table, bit counter
// and cascade output for the LUT5 loader.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture data_i into the holding register, clear counter
//   data_i     : word to capture
//   shift_i    : shift one hold bit (MSB first) into the shadow table
//   shadow_o   : shadow table contents
//   cdo_o      : shadow bit 31 (bit leaving the shadow on the next shift)
//   last_o     : the current shift moves the final bit
// Optional (X_LUT5_CFG_PARITY_EN):
//   par_i      : parity bit captured with the word
//   par_err_o  : captured word and parity bit have odd combined parity
module x_lut5_cfg_shifter
    import x_lut5_pkg::*;
#(
    parameter table_t INIT = '0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  table_t data_i,
    input  logic   shift_i,
`ifdef X_LUT5_CFG_PARITY_EN
    input  logic   par_i,
    output logic   par_err_o,
`endif
    output table_t shadow_o,
    output logic   cdo_o,
    output logic   last_o
);
    table_t           hold_q;
    table_t           shadow_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef X_LUT5_CFG_PARITY_EN
    logic             par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            shadow_q <= INIT;
            cnt_q    <= '0;
`ifdef X_LUT5_CFG_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (load_i) begin
            hold_q <= data_i;
            cnt_q  <= '0;
`ifdef X_LUT5_CFG_PARITY_EN
            par_q  <= par_i;
`endif
        end else if (shift_i) begin
            // ~cnt_q == 31 - cnt_q: feed hold bits MSB first
            shadow_q <= {shadow_q[TABLE_W-2:0], hold_q[~cnt_q]};
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign shadow_o = shadow_q;
    assign cdo_o    = shadow_q[TABLE_W-1];
    assign last_o   = (cnt_q == {CNT_W{1'b1}});
`ifdef X_LUT5_CFG_PARITY_EN
    assign par_err_o = (^hold_q) ^ par_q;
`endif
endmodule

// File: rtl/x_lut5_cfg_loader.sv
// x_lut5_cfg_loader: run-time reconfigurable 5-input LUT. A 32-bit truth table
// arrives over a valid/ready handshake, is shifted serially into a shadow
// table and then committed atomically to the active table driving O.
//   CLK, RST      : clock, synchronous active-high reset
//   cfg (slave)   : configuration handshake (see x_lut5_cfg_loader_if)
//   ADR0..ADR4    : lookup address, ADR4 is the MSB
//   O             : combinational lookup of the active table
//   O_Q           : O registered on CLK
//   CDO           : serial cascade out (shadow bit 31)
// Parameters: INIT (reset table), LOC (placement only, no function).
// Build option: define X_LUT5_CFG_PARITY_EN to add CFG_PAR/CFG_ERR checking;
// a word with bad parity is not committed.
module x_lut5_cfg_loader
    import x_lut5_pkg::*;
#(
    parameter table_t INIT = 32'h00000000,
    parameter         LOC  = "UNPLACED"
) (
    input  logic                  CLK,
    input  logic                  RST,
    x_lut5_cfg_loader_if.slave    cfg,
    input  logic                  ADR0,
    input  logic                  ADR1,
    input  logic                  ADR2,
    input  logic                  ADR3,
    input  logic                  ADR4,
    output logic                  O,
    output logic                  O_Q,
    output logic                  CDO
);
    state_e state_q;
    table_t active_q;
    logic   ready_q, busy_q, done_q, o_q;
    table_t shadow;
    logic   last;
    logic   par_bad;
    logic   load, shift;

    assign load  = (state_q == IDLE) && cfg.CFG_VALID;
    assign shift = (state_q == SHIFT);

    x_lut5_cfg_shifter #(.INIT(INIT)) u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .load_i    (load),
        .data_i    (cfg.CFG_DATA),
        .shift_i   (shift),
`ifdef X_LUT5_CFG_PARITY_EN
        .par_i     (cfg.CFG_PAR),
        .par_err_o (par_bad),
`endif
        .shadow_o  (shadow),
        .cdo_o     (CDO),
        .last_o    (last)
    );

`ifdef X_LUT5_CFG_PARITY_EN
    logic err_q;
    assign cfg.CFG_ERR = err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            active_q <= INIT;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            o_q      <= 1'b0;
`ifdef X_LUT5_CFG_PARITY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            o_q    <= O;
            done_q <= 1'b0;
`ifdef X_LUT5_CFG_PARITY_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cfg.CFG_VALID) begin
                        state_q <= SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last) state_q <= COMMIT;
                end
                COMMIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    // DONE/ERR land on the same edge the table would switch
                    if (par_bad) begin
`ifdef X_LUT5_CFG_PARITY_EN
                        err_q <= 1'b1;
`endif
                    end else begin
                        active_q <= shadow;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Only the committed table is ever visible on O
    assign O             = active_q[{ADR4, ADR3, ADR2, ADR1, ADR0}];
    assign O_Q           = o_q;
    assign cfg.CFG_READY = ready_q;
    assign cfg.CFG_BUSY  = busy_q;
    assign cfg.CFG_DONE  = done_q;
endmodule

// File: tb/tb_x_lut5_cfg_loader.sv
module tb_x_lut5_cfg_loader;
    localparam logic [31:0] INIT_V = 32'hAAAAAAAA;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ADR0 = 1'b0, ADR1 = 1'b0, ADR2 = 1'b0, ADR3 = 1'b0, ADR4 = 1'b0;
    logic O, O_Q, CDO;

    x_lut5_cfg_loader_if cfg();

    x_lut5_cfg_loader #(.INIT(INIT_V), .LOC("X0Y0")) dut (
        .CLK(CLK), .RST(RST), .cfg(cfg),
        .ADR0(ADR0), .ADR1(ADR1), .ADR2(ADR2), .ADR3(ADR3), .ADR4(ADR4),
        .O(O), .O_Q(O_Q), .CDO(CDO)
    );

    always #50 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_act, m_shd;   // reference active and shadow tables

    task automatic set_adr(input logic [4:0] a);
        {ADR4, ADR3, ADR2, ADR1, ADR0} = a;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Full handshake + 33-edge transfer, checking every cycle along the way.
    task automatic do_load(input logic [31:0] w, input logic par, input bit keep);
        logic [31:0] cdo_seen;
        logic [4:0]  a;
        logic        ok;
        int          n;
        ok = 1'b1;
`ifdef X_LUT5_CFG_PARITY_EN
        ok = ((^w) ^ par) == 1'b0;
`endif
        n = 0;
        while (cfg.CFG_READY !== 1'b1 && n < 40) begin tick; n++; end
        total++;
        if (cfg.CFG_READY !== 1'b1) begin
            bad++; $display("FAIL ready_wait: ready=%b want 1", cfg.CFG_READY);
        end
        cfg.CFG_DATA  = w;
        cfg.CFG_VALID = 1'b1;
`ifdef X_LUT5_CFG_PARITY_EN
        cfg.CFG_PAR   = par;
`endif
        tick;  // acceptance edge k
        if (!keep) cfg.CFG_VALID = 1'b0;
        for (int j = 0; j <= 32; j++) begin
            a = 5'($urandom_range(0, 31));
            set_adr(a);
            #1;
            if (j < 32) cdo_seen[31-j] = CDO;
            total++;
            if ({cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE} !== 3'b010) begin
                bad++; $display("FAIL hs_shift j=%0d: rdy/busy/done=%b want 010", j,
                                {cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE});
            end
            total++;
            if (O !== m_act[a]) begin
                bad++; $display("FAIL o_during_shift j=%0d adr=%0d: got %b want %b", j, a, O, m_act[a]);
            end
            tick;
        end
        // now just past edge k+33
        total++;
        if ({cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE} !== {2'b10, ok}) begin
            bad++; $display("FAIL commit_hs: rdy/busy/done=%b want %b",
                            {cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE}, {2'b10, ok});
        end
`ifdef X_LUT5_CFG_PARITY_EN
        total++;
        if (cfg.CFG_ERR !== ~ok) begin
            bad++; $display("FAIL commit_err: got %b want %b", cfg.CFG_ERR, ~ok);
        end
`endif
        total++;
        if (cdo_seen !== m_shd) begin
            bad++; $display("FAIL cdo_chain: got %h want %h", cdo_seen, m_shd);
        end
        m_shd = w;
        if (ok) m_act = w;
        for (int i = 0; i < 32; i++) begin
            set_adr(5'(i));
            #1;
            total++;
            if (O !== m_act[i]) begin
                bad++; $display("FAIL o_after_commit adr=%0d: got %b want %b", i, O, m_act[i]);
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        cfg.CFG_VALID = 1'b0;
        cfg.CFG_DATA  = '0;
`ifdef X_LUT5_CFG_PARITY_EN
        cfg.CFG_PAR   = 1'b0;
`endif
        tick; tick;
        RST = 1'b0;
        m_act = INIT_V; m_shd = INIT_V;
        total++;
        if ({cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE, O_Q, CDO} !== {4'b1000, INIT_V[31]}) begin
            bad++; $display("FAIL reset_outputs: rdy/busy/done/oq/cdo=%b want 1000%b",
                            {cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE, O_Q, CDO}, INIT_V[31]);
        end
`ifdef X_LUT5_CFG_PARITY_EN
        total++;
        if (cfg.CFG_ERR !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", cfg.CFG_ERR); end
`endif
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            set_adr(a);
            #1;
            total++;
            if (O !== a[0]) begin bad++; $display("FAIL reset_o adr=%0d: got %b want %b", i, O, a[0]); end
        end
    endtask

    task automatic test_corner_load;
        do_load(32'h80000001, ^32'h80000001, 1'b0);
        for (int i = 0; i < 32; i++) begin
            set_adr(5'(i));
            #1;
            total++;
            if (O !== (i == 0 || i == 31)) begin
                bad++; $display("FAIL corner_o adr=%0d: got %b", i, O);
            end
        end
        tick;
        total++;
        if (cfg.CFG_DONE !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", cfg.CFG_DONE); end
    endtask

    task automatic test_back_to_back;
        do_load(32'hFFFF0000, ^32'hFFFF0000, 1'b1);
        // VALID still high: next edge (k+34) must accept
        do_load(32'h0000FFFF, ^32'h0000FFFF, 1'b0);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            set_adr(a);
            #1;
            total++;
            if (O !== ~a[4]) begin bad++; $display("FAIL b2b_o adr=%0d: got %b want %b", i, O, ~a[4]); end
        end
    endtask

    task automatic test_chain;
        do_load(32'h12345678, ^32'h12345678, 1'b0);
        do_load(32'hFFFFFFFF, ^32'hFFFFFFFF, 1'b0);  // CDO must replay 12345678
    endtask

    task automatic test_oq;
        for (int k = 0; k < 8; k++) begin
            logic [4:0] a;
            logic       e;
            a = 5'($urandom_range(0, 31));
            set_adr(a);
            e = m_act[a];
            tick;
            total++;
            if (O_Q !== e) begin bad++; $display("FAIL o_q adr=%0d: got %b want %b", a, O_Q, e); end
        end
    endtask

    task automatic test_reset_mid_shift;
        cfg.CFG_DATA  = 32'hDEADBEEF;
        cfg.CFG_VALID = 1'b1;
`ifdef X_LUT5_CFG_PARITY_EN
        cfg.CFG_PAR   = ^32'hDEADBEEF;
`endif
        tick;
        cfg.CFG_VALID = 1'b0;
        repeat (15) tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        m_act = INIT_V; m_shd = INIT_V;
        total++;
        if ({cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE, CDO} !== {3'b100, INIT_V[31]}) begin
            bad++; $display("FAIL midreset_outputs: rdy/busy/done/cdo=%b",
                            {cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE, CDO});
        end
        for (int i = 0; i < 32; i++) begin
            set_adr(5'(i));
            #1;
            total++;
            if (O !== INIT_V[i]) begin bad++; $display("FAIL midreset_o adr=%0d: got %b want %b", i, O, INIT_V[i]); end
        end
        tick;
        total++;
        if ({cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE} !== 3'b100) begin
            bad++; $display("FAIL midreset_next: rdy/busy/done=%b want 100",
                            {cfg.CFG_READY, cfg.CFG_BUSY, cfg.CFG_DONE});
        end
        // the discarded word must not surface as CDO history
        do_load(32'h0F0F3C3C, ^32'h0F0F3C3C, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = $urandom;
            do_load(w, ^w, 1'b0);
        end
    endtask

`ifdef X_LUT5_CFG_PARITY_EN
    task automatic test_parity;
        logic [31:0] before;
        before = m_act;
        do_load(32'h00000001, 1'b0, 1'b0);  // odd parity: rejected
        total++;
        if (m_act !== before) begin bad++; $display("FAIL parity_model: table changed"); end
        do_load(32'h00000001, 1'b1, 1'b0);  // good parity: committed
        set_adr(5'd0);
        #1;
        total++;
        if (O !== 1'b1) begin bad++; $display("FAIL parity_o0: got %b want 1", O); end
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_corner_load;
        test_back_to_back;
        test_chain;
        test_oq;
        test_reset_mid_shift;
        test_random;
`ifdef X_LUT5_CFG_PARITY_EN
        test_parity;
`endif
        test_oq;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
